// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction
// memory, buffers {pc, instr} pairs in a prefetch FIFO and hands them to decode
// over a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  output logic [31:0]                   imem_addr_o,
  input  logic [31:0]                   imem_instr_i,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_pc_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [31:0]                   instr_o,
  output logic [31:0]                   pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  // Redirect targets are word-aligned by dropping the low bits.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc_i[1:0];

  assign instr_valid_o = (count != '0);
  assign pop           = instr_valid_o & instr_ready_i;
  // A full FIFO can still accept a fetch when the head leaves this cycle.
  assign push          = enable_i & ~redirect_i & ((count < CW'(FIFO_DEPTH)) | pop);

  assign imem_addr_o   = fetch_pc;
  assign fifo_count_o  = count;
  assign instr_o       = instr_valid_o ? instr_mem[head] : '0;
  assign pc_o          = instr_valid_o ? pc_mem[head]    : '0;

  // Fetch PC, FIFO pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO payload storage, written at the tail on every push.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload array is deliberately not reset; outputs are gated by
    // instr_valid_o, so stale contents are never observable.
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_instr_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based reference model is
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_ready_i;

  logic [31:0] imem_addr_o, imem_instr_i, instr_o, pc_o;
  logic        instr_valid_o;
  logic [2:0]  fifo_count_o;

  logic [31:0] imem_addr2, imem_instr2, instr2, pc2;
  logic        valid2;
  logic [2:0]  count2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);
  assign imem_instr2  = mem_word(imem_addr2);

  always #5 clk_i = ~clk_i;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .fifo_count_o(fifo_count_o)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .imem_addr_o(imem_addr2), .imem_instr_i(imem_instr2),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(valid2), .instr_ready_i(instr_ready_i),
    .instr_o(instr2), .pc_o(pc2), .fifo_count_o(count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus the fetch PC.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q.delete();
      m_pc = 32'h0;
    end else if (redirect_i) begin
      q.delete();
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (q.size() > 0) && instr_ready_i;
      do_push = enable_i && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare the DUT against the model every cycle, away from the rising edge.
  always @(negedge clk_i) begin
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_pc    = (q.size() > 0) ? q[0].pc    : 32'h0;
    e_instr = (q.size() > 0) ? q[0].instr : 32'h0;
    check("model_valid", {31'b0, instr_valid_o}, {31'b0, q.size() > 0});
    check("model_count", 32'(fifo_count_o), 32'(q.size()));
    check("model_pc",    pc_o,    e_pc);
    check("model_instr", instr_o, e_instr);
    check("model_addr",  imem_addr_o, m_pc);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    tick();
    rst_i      = 1'b1;
    redirect_i = 1'b0;
    tick();
    instr_ready_i = ready;
    rst_i         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wrap_pc [3];
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;

    rst_i = 1'b1; enable_i = 1'b1; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; instr_ready_i = 1'b1;

    // Streaming with decode always ready: one entry in flight every cycle.
    do_reset(1'b1);
    @(negedge clk_i);
    check("reset_valid", {31'b0, instr_valid_o}, 32'h0);
    check("reset_count", 32'(fifo_count_o), 32'h0);
    check("reset_addr",  imem_addr_o, 32'h0);
    check("reset_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("stream_pc",    pc_o, 32'(4 * k));
      check("stream_instr", instr_o, 32'h1000_0000 + 32'(k));
      check("stream_count", 32'(fifo_count_o), 32'h1);
      if (k < 3) begin
        check("wrap_valid", {31'b0, valid2}, 32'h1);
        check("wrap_pc",    pc2, wrap_pc[k]);
      end
    end

    // Back-pressure: FIFO fills to 4 and the fetch PC stalls at 0x10.
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("fill_count", 32'(fifo_count_o), (i < 4) ? 32'(i) : 32'h4);
    end
    check("fill_addr", imem_addr_o, 32'h10);
    tick();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("full_pop_count", 32'(fifo_count_o), 32'h4);
    check("full_pop_addr",  imem_addr_o, 32'h14);
    check("full_pop_pc",    pc_o, 32'h4);
    tick();
    instr_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_i);
      check("drain_pc",    pc_o, 32'h4 + 32'(4 * j));
      check("drain_instr", instr_o, 32'h1000_0001 + 32'(j));
    end

    // Redirect to a misaligned target while three entries are held.
    do_reset(1'b0);
    tick(); tick(); tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0042;
    instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("redir_count", 32'(fifo_count_o), 32'h0);
    check("redir_valid", {31'b0, instr_valid_o}, 32'h0);
    check("redir_addr",  imem_addr_o, 32'h40);
    @(negedge clk_i);
    check("redir_pc",    pc_o, 32'h40);
    check("redir_instr", instr_o, 32'h1000_0010);

    // Fetch disabled: FIFO drains, fetch PC holds.
    tick();
    enable_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    check("disable_count", 32'(fifo_count_o), 32'h0);
    check("disable_addr",  imem_addr_o, 32'h48);
    enable_i = 1'b1;

    // Asynchronous reset mid-cycle with two entries held.
    do_reset(1'b0);
    tick(); tick();
    #3;
    rst_i = 1'b1;
    #1;
    check("async_valid", {31'b0, instr_valid_o}, 32'h0);
    check("async_count", 32'(fifo_count_o), 32'h0);
    check("async_addr",  imem_addr_o, 32'h0);
    tick();
    rst_i = 1'b0;
    instr_ready_i = 1'b1;
    tick(); tick(); tick();

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
